// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

   typedef enum logic {ST_STABLE, ST_PEND} db_state_t;

   localparam int unsigned DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/debounce_ch.sv
// One debounced channel: 2-FF synchroniser, stability counter, FSM, level and edge strobes.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic            s1_q, s1_d;
   logic            s2_q, s2_d;
   db_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   logic            busy_q, busy_d;

   always_comb begin
      s1_d    = raw;
      s2_d    = s1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         ST_STABLE: begin
            if (s2_q != level_q) begin
               state_d = ST_PEND;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         ST_PEND: begin
            if (s2_q == level_q) begin
               // Input bounced back before becoming stable: drop it silently.
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               level_d = ~level_q;
               rise_d  = ~level_q;
               fall_d  = level_q;
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == ST_PEND);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign busy  = busy_q;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel switch conditioner; level[1:0] feeds a/b of the downstream XOR top.
module switch_debounce
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH          = 2,
   parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic            busy
);

   logic [N_CH-1:0] busy_ch;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (raw[i]),
         .level(level[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .busy (busy_ch[i])
      );
   end

   assign busy = |busy_ch;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed-vector scoreboard bench for switch_debounce with STABLE_CYCLES = 4.
module tb_switch_debounce;

   localparam int unsigned SC = 4;

   typedef struct {
      logic [1:0] lv;
      logic [1:0] ri;
      logic [1:0] fa;
      logic       b;
      int         phase;
      int         idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] raw = 2'b00;
   logic [1:0] level, rise, fall;
   logic       busy;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   phase  = 0;
   int   idx    = 0;

   switch_debounce #(
      .N_CH         (2),
      .STABLE_CYCLES(SC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw),
      .level(level),
      .rise (rise),
      .fall (fall),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs and queue the outputs expected after the next rising edge.
   task automatic step(input logic r, input logic [1:0] rw, input logic [1:0] lv,
                       input logic [1:0] ri, input logic [1:0] fa, input logic b);
      exp_t e;
      rst_n   = r;
      raw     = rw;
      e.lv    = lv;
      e.ri    = ri;
      e.fa    = fa;
      e.b     = b;
      e.phase = phase;
      e.idx   = idx;
      idx++;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic quiet(input int n, input logic [1:0] rw, input logic [1:0] lv);
      for (int i = 0; i < n; i++) step(1'b1, rw, lv, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic new_phase(input int p);
      phase = p;
      idx   = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (level !== e.lv) begin
               errors++;
               $display("FAIL level phase %0d step %0d: got %b expected %b",
                        e.phase, e.idx, level, e.lv);
            end
            checks++;
            if (rise !== e.ri) begin
               errors++;
               $display("FAIL rise phase %0d step %0d: got %b expected %b",
                        e.phase, e.idx, rise, e.ri);
            end
            checks++;
            if (fall !== e.fa) begin
               errors++;
               $display("FAIL fall phase %0d step %0d: got %b expected %b",
                        e.phase, e.idx, fall, e.fa);
            end
            checks++;
            if (busy !== e.b) begin
               errors++;
               $display("FAIL busy phase %0d step %0d: got %b expected %b",
                        e.phase, e.idx, busy, e.b);
            end
         end
      end
   end

   initial begin : stimulus
      logic bounce_raw [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic bounce_busy[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      // Phase 1: reset held with raw=11, then release debounces as a rising edge.
      new_phase(1);
      repeat (3) step(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (2) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0);
      quiet(2, 2'b11, 2'b11);

      // Phase 2: both channels fall together.
      new_phase(2);
      repeat (2) step(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0);
      quiet(2, 2'b00, 2'b00);

      // Phase 3: clean edge on channel 0 only, up then down.
      new_phase(3);
      repeat (2) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
      quiet(2, 2'b01, 2'b01);
      repeat (2) step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      quiet(2, 2'b00, 2'b00);

      // Phase 4: fast bounce never settles; busy pulses, level stays low.
      new_phase(4);
      for (int i = 0; i < 11; i++)
         step(1'b1, {1'b0, bounce_raw[i]}, 2'b00, 2'b00, 2'b00, bounce_busy[i]);

      // Phase 5a: 3-cycle pulse is one sample short and is rejected.
      new_phase(5);
      repeat (2) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      repeat (2) step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      quiet(2, 2'b00, 2'b00);

      // Phase 6: 4-cycle pulse is the shortest accepted; one rise then one fall.
      new_phase(6);
      repeat (2) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (2) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      quiet(2, 2'b00, 2'b00);

      // Phase 7: 5-cycle pulse; one rise, a stable gap, then one fall.
      new_phase(7);
      repeat (2) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);
      step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      quiet(2, 2'b00, 2'b00);

      // Phase 8: simultaneous rise on both channels.
      new_phase(8);
      repeat (2) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0);
      quiet(2, 2'b11, 2'b11);

      // Phase 9: reset during a pending fall clears level without a fall strobe.
      new_phase(9);
      repeat (2) step(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
      step(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
      repeat (2) step(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      quiet(2, 2'b00, 2'b00);

      // Phase 10: reset during a pending rise on channel 1, then full-latency rise.
      new_phase(10);
      repeat (2) step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (2) step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
      repeat (3) step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
      step(1'b1, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0);
      quiet(2, 2'b10, 2'b10);

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
